// File: rtl/ccff_loader_pkg.sv
//------------------------------------------------------------------------------
// Module   : ccff_loader_pkg
// Brief    : Shared state encoding and CRC-8 constants for the CCFF loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CRC_WAIT = 3'd3,
    ST_DONE     = 3'd4
  } ccff_state_t;

  localparam logic [7:0] CCFF_CRC_POLY = 8'h07;
  localparam logic [7:0] CCFF_CRC_INIT = 8'h00;

endpackage

`default_nettype wire

// File: rtl/ccff_crc8_serial.sv
//------------------------------------------------------------------------------
// Module   : ccff_crc8_serial
// Brief    : Bit-serial CRC-8 (MSB-first LFSR) with synchronous clear.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ccff_crc8_serial
  import ccff_loader_pkg::*;
(
  input  logic       clk,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;
  logic       w_fb;

  assign w_fb = r_crc[7] ^ i_bit;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_crc <= CCFF_CRC_INIT;
    end else if (i_en) begin
      r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? CCFF_CRC_POLY : 8'h00);
    end
  end

  assign o_crc = r_crc;

endmodule

`default_nettype wire

// File: rtl/ccff_config_loader.sv
//------------------------------------------------------------------------------
// Module   : ccff_config_loader
// Brief    : Serialises parallel config words LSB-first into the CCFF chain.
//            Optional trailing CRC-8 check enabled by CCFF_CRC_CHECK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ccff_config_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Bits per word never exceed the chain, so the bit counter width covers it.
  localparam int              c_word_cap  = (WORD_W < CHAIN_LEN) ? WORD_W : CHAIN_LEN;
  localparam logic [CNT_W-1:0] c_word_bits = CNT_W'(c_word_cap);
  localparam logic [CNT_W-1:0] c_chain_len = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  ccff_state_t       r_state;
  ccff_state_t       w_state_nxt;
  logic [WORD_W-1:0] r_sreg;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_rem;
  logic              r_head;
  logic              r_shift_en;

  logic              w_start_ok;
  logic              w_accept;
  logic              w_shift_next;
  logic [CNT_W-1:0]  w_left;
  logic [CNT_W-1:0]  w_nbits;
`ifdef CCFF_CRC_CHECK_EN
  logic              w_crc_accept;
`endif

  assign w_left  = c_chain_len - r_count;
  assign w_nbits = (w_left > c_word_bits) ? c_word_bits : w_left;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start_ok   = 1'b0;
    w_accept     = 1'b0;
    w_shift_next = 1'b0;
`ifdef CCFF_CRC_CHECK_EN
    w_crc_accept = 1'b0;
`endif
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (s_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // r_rem counts bits still to apply after the one on ccff_head now
        if (r_rem != '0) begin
          w_shift_next = 1'b1;
        end else if (r_count < c_chain_len) begin
          w_state_nxt = ST_LOAD;
        end else begin
`ifdef CCFF_CRC_CHECK_EN
          w_state_nxt = ST_CRC_WAIT;
`else
          w_state_nxt = ST_DONE;
`endif
        end
      end
`ifdef CCFF_CRC_CHECK_EN
      ST_CRC_WAIT: begin
        if (s_valid) begin
          w_crc_accept = 1'b1;
          w_state_nxt  = ST_DONE;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_sreg     <= '0;
      r_count    <= '0;
      r_rem      <= '0;
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
    end else begin
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
      if (w_start_ok) begin
        r_count <= '0;
      end
      if (w_accept) begin
        r_sreg     <= s_data >> 1;
        r_head     <= s_data[0];
        r_shift_en <= 1'b1;
        r_count    <= r_count + c_one;
        r_rem      <= w_nbits - c_one;
      end
      if (w_shift_next) begin
        r_sreg     <= r_sreg >> 1;
        r_head     <= r_sreg[0];
        r_shift_en <= 1'b1;
        r_count    <= r_count + c_one;
        r_rem      <= r_rem - c_one;
      end
    end
  end

`ifdef CCFF_CRC_CHECK_EN
  logic [7:0] w_crc;
  logic       r_error;

  // CRC follows the registered chain outputs, so it is final when CRC_WAIT begins
  ccff_crc8_serial u_crc (
    .clk   (prog_clk),
    .i_clr (pReset | w_start_ok),
    .i_en  (r_shift_en),
    .i_bit (r_head),
    .o_crc (w_crc)
  );

  always_ff @(posedge prog_clk) begin
    if (pReset || w_start_ok) begin
      r_error <= 1'b0;
    end else if (w_crc_accept && (s_data[7:0] != w_crc)) begin
      r_error <= 1'b1;
    end
  end

  assign error   = r_error;
  assign s_ready = (r_state == ST_LOAD) || (r_state == ST_CRC_WAIT);
  assign busy    = (r_state == ST_LOAD) || (r_state == ST_SHIFT) || (r_state == ST_CRC_WAIT);
`else
  assign error   = 1'b0;
  assign s_ready = (r_state == ST_LOAD);
  assign busy    = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
`endif

  assign done          = (r_state == ST_DONE);
  assign ccff_head     = r_head;
  assign ccff_shift_en = r_shift_en;

endmodule

`default_nettype wire

// File: tb/tb_ccff_config_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_ccff_config_loader
// Brief    : Self-checking bench for ccff_config_loader (WORD_W=8, CHAIN_LEN=20).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ccff_config_loader;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 20;

  logic        prog_clk = 1'b0;
  logic        pReset   = 1'b1;
  logic        start    = 1'b0;
  logic        s_valid  = 1'b0;
  logic [7:0]  s_data   = 8'h00;
  logic        s_ready;
  logic        ccff_head;
  logic        ccff_shift_en;
  logic        busy;
  logic        done;
  logic        error;

  int          checks   = 0;
  int          errors   = 0;
  int          head_bad = 0;
  logic        got_q[$];

  always #5 prog_clk = ~prog_clk;

  ccff_config_loader #(
    .WORD_W    (WORD_W),
    .CHAIN_LEN (CHAIN_LEN)
  ) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  // Records every bit the chain would capture
  always @(negedge prog_clk) begin
    if (ccff_shift_en === 1'b1) got_q.push_back(ccff_head);
    else if (ccff_head !== 1'b0) head_bad++;
  end

  task automatic tick();
    @(negedge prog_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1, first bit = highest degree
  function automatic logic [7:0] crc_ref(input logic [19:0] bits);
    int         r[28];
    int         g[9];
    logic [7:0] c;
    g = '{1, 0, 0, 0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 28; i++) r[i] = (i < 20) ? int'(bits[i]) : 0;
    for (int i = 0; i < 20; i++)
      if (r[i] != 0)
        for (int j = 0; j < 9; j++) r[i+j] = r[i+j] ^ g[j];
    for (int k = 0; k < 8; k++) c[7-k] = (r[20+k] != 0);
    return c;
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ready", s_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_done_low", done, 0);
    chk("start_error_low", error, 0);
  endtask

  task automatic send_word(input logic [7:0] w, input int stall, input bit pulse_start, input bit is_data);
    int n;
    n = 0;
    while (s_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("ready_wait", n < 100, 1);
    for (int i = 0; i < stall; i++) begin
      s_valid = 1'b0;
      start   = pulse_start && (i == 0);
      tick();
      start   = 1'b0;
      chk("stall_ready", s_ready, 1);
      chk("stall_no_shift", ccff_shift_en, 0);
    end
    s_data  = w;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    if (is_data) begin
      chk("first_shift_en", ccff_shift_en, 1);
      chk("first_bit", ccff_head, w[0]);
    end
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input int stall, input bit mid_start,
                         input bit force_trail, input logic [7:0] trail_val);
    logic [7:0]  wa[3];
    logic [19:0] exp_vec;
    logic [19:0] got_vec;
    logic [7:0]  trail;
    int          n;
    wa = '{a, b, c};
    for (int k = 0; k < CHAIN_LEN; k++) exp_vec[k] = wa[k/8][k%8];
    got_q.delete();
    head_bad = 0;
    do_start();
    for (int i = 0; i < 3; i++) send_word(wa[i], (i == 0) ? 0 : stall, mid_start && (i == 1), 1'b1);
    n = 0;
    while (got_q.size() < CHAIN_LEN && n < 100) begin
      tick();
      n++;
    end
    chk("shift_timeout", n < 100, 1);
`ifdef CCFF_CRC_CHECK_EN
    trail = force_trail ? trail_val : crc_ref(exp_vec);
    send_word(trail, 0, 1'b0, 1'b0);
    chk("done_after_crc", done, 1);
    chk("crc_error", error, (trail != crc_ref(exp_vec)));
`else
    trail = force_trail ? trail_val : 8'h00;
    tick();
    chk("done_after_last", done, 1);
    chk("no_shift_after_last", ccff_shift_en, 0);
    chk("error_tied", error, 0);
`endif
    repeat (3) tick();
    got_vec = '0;
    for (int k = 0; k < got_q.size() && k < CHAIN_LEN; k++) got_vec[k] = got_q[k];
    chk("shift_count", got_q.size(), CHAIN_LEN);
    chk("bitseq", got_vec, exp_vec);
    chk("head_idle_zero", head_bad, 0);
    chk("done_held", done, 1);
    chk("not_busy", busy, 0);
    chk("ready_low_done", s_ready, 0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    chk("rst_ready", s_ready, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_shift_en", ccff_shift_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    pReset = 1'b0;
    tick();
    chk("idle_done_low", done, 0);

    // Basic load, then 5-cycle stalls, partial 0xFF, ignored start
    do_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 1'b0, 8'h00);
    do_load(8'hA5, 8'h3C, 8'h0F, 5, 1'b0, 1'b0, 8'h00);
    do_load(8'h12, 8'h34, 8'hFF, 0, 1'b0, 1'b0, 8'h00);
    do_load(8'hA5, 8'h3C, 8'h0F, 2, 1'b1, 1'b0, 8'h00);

    // Randomized loads
    for (int it = 0; it < 6; it++)
      do_load(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 5),
              1'($urandom_range(0, 1)), 1'b0, 8'h00);

    // Reset during second word's shift
    got_q.delete();
    do_start();
    send_word(8'h5A, 0, 1'b0, 1'b1);
    send_word(8'hC3, 0, 1'b0, 1'b1);
    tick();
    tick();
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_shift_en", ccff_shift_en, 0);
    chk("mrst_done", done, 0);
    chk("mrst_ready", s_ready, 0);
    n = got_q.size();
    repeat (3) tick();
    chk("mrst_no_shift", got_q.size(), n);
    do_load(8'($urandom), 8'($urandom), 8'($urandom), 1, 1'b0, 1'b0, 8'h00);

`ifdef CCFF_CRC_CHECK_EN
    do_load(8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1, 8'h00);
    do_load(8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1, 8'h01);
    chk("crc_err_sticky", error, 1);
    do_start();
    chk("crc_err_cleared", error, 0);
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
    do_load(8'($urandom), 8'($urandom), 8'($urandom), 0, 1'b0, 1'b0, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ccff_config_loader.md
# ccff_config_loader

- Streams a configuration bitstream into the fabric's configuration flip-flop chain, which holds the `mem`/`mem_inv` select bits of the routing and LUT multiplexer primitives.
- Accepts parallel words over a valid/ready handshake, serialises them LSB-first onto `ccff_head`, and counts bits until exactly `CHAIN_LEN` bits have been shifted.
- Drives `ccff_shift_en` high only in cycles where a bit is applied, so chain flops outside shift cycles hold their value.
- Sits between the programming interface and the top-level `ccff_head` pin of the fabric.

## Interface

Parameters:
- `WORD_W`, default 8: input word width. Must be ≥ 8 when the CRC feature is compiled in.
- `CHAIN_LEN`, default 1024: total configuration bits in the chain. Must be ≥ 1.
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: width of the bit counter.

Ports:
- `prog_clk`  in  1  programming clock; the only clock.
- `pReset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a load. Honoured only in IDLE or DONE.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  `WORD_W`  input word.
- `ccff_head`  out  1  serial bit into the chain.
- `ccff_shift_en`  out  1  chain shift enable; one bit per high cycle.
- `busy`  out  1  a load is in progress.
- `done`  out  1  load finished.
- `error`  out  1  CRC mismatch; tied 0 without the macro.

## Operation

- States: IDLE, LOAD, SHIFT, CRC_WAIT (macro only), DONE.
- **IDLE / DONE:**
  - `start` clears the bit counter, the CRC register and `error`, then goes to LOAD.
  - `done` is 1 in DONE and 0 in IDLE.
- **LOAD:**
  - `s_ready`=1.
  - On `s_valid && s_ready`, `s_data` is captured into the shift register. Bits to send = min(`WORD_W`, `CHAIN_LEN` − count). Go to SHIFT.
- **SHIFT:**
  - Each cycle: `ccff_head`=sreg[0], `ccff_shift_en`=1, sreg shifts right, count increments.
  - After the last bit of the word:
    - if count < `CHAIN_LEN`, go to LOAD;
    - otherwise go to CRC_WAIT (macro) or DONE.
  - In a final partial word, the unused upper bits are discarded.
- **Chain order:** the first bit shifted ends at the chain tail (deepest flop); the last bit ends at the head.
- **`busy`** = 1 in LOAD, SHIFT and CRC_WAIT.
- **Ignored inputs:**
  - `start` is ignored while busy.
  - `s_valid` is ignored outside LOAD and CRC_WAIT. No overflow or underflow condition exists; the loader stalls in LOAD indefinitely while `s_valid`=0.
- **Reset:**
  - `pReset` at any time returns the FSM to IDLE and clears sreg, count and CRC on the same edge.
  - A partially loaded chain is left as-is; software must restart the load.

## Timing

- Reset values: `s_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `error`=0.
- `start` at edge N puts the FSM in LOAD, so `s_ready`=1 in cycle N+1.
- Handshake at edge M puts the first bit on `ccff_head` with `ccff_shift_en`=1 in cycle M+1.
- A full word costs `WORD_W` shift cycles plus 1 LOAD cycle; there is no overlap between load and shift.
- `ccff_head` and `ccff_shift_en` are registered outputs. `ccff_head` holds 0 when not shifting.
- `done` asserts the cycle after the last shift (without the macro) or the cycle after the CRC word handshake (with it). It stays high until `start` or reset.

## Configuration

- **`CCFF_CRC_CHECK_EN` defined:**
  - A serial CRC-8 (polynomial 0x07, initial value 0x00) updates on every shifted bit, using the `ccff_head` value.
  - After the final bit the FSM enters CRC_WAIT with `s_ready`=1 and accepts one trailing word.
  - If `s_data[7:0]` ≠ CRC, then `error`=1.
  - The FSM goes to DONE in either case.
- **Macro not defined:**
  - No CRC logic and no CRC_WAIT state.
  - No trailing word is consumed.
  - `error` is tied to 0.

## Structure

- Package `ccff_loader_pkg` holds:
  - the state enum `ccff_state_t`;
  - `CCFF_CRC_POLY = 8'h07`;
  - `CCFF_CRC_INIT = 8'h00`.
- Sub-module `ccff_crc8_serial` (inputs: clk, sync clear, bit enable, bit in; output: 8-bit CRC). It is instantiated only under `CCFF_CRC_CHECK_EN`.

## Test plan

All scenarios use `WORD_W`=8 and `CHAIN_LEN`=20.

- **Basic load:** `start`, then words 0xA5, 0x3C, 0x0F.
  - `ccff_head` sequence is 1,0,1,0,0,1,0,1 / 0,0,1,1,1,1,0,0 / 1,1,1,1.
  - Exactly 20 `ccff_shift_en` cycles.
  - `done`=1 after the 20th shift.
- **Stall:** hold `s_valid`=0 for 5 cycles between words.
  - No `ccff_shift_en` pulses during the stall.
  - `s_ready` stays 1; the output bit sequence is unchanged.
- **Partial last word:** third word 0xFF.
  - Only 4 ones are shifted; the 21st `ccff_shift_en` never occurs.
- **Ignored start:** `start` pulsed mid-load.
  - No effect: count and `ccff_head` sequence are identical to the basic load.
- **Reset mid-operation:** `pReset` during the 2nd word's SHIFT.
  - Next cycle: `busy`=0, `ccff_shift_en`=0, `done`=0.
  - A fresh `start` reloads a full 20 bits.
- **CRC (macro on):** three 0x00 words.
  - Trailing word 0x00 gives `done`=1, `error`=0.
  - Repeating with trailing word 0x01 gives `done`=1, `error`=1.
  - A following `start` clears `error`.
